// File: rtl/channel_in_acc_ctrl_pkg.sv
// Shared types and defaults for the adder-tree sequencer/accumulator.
package channel_in_acc_ctrl_pkg;

  localparam int PICTURE_NUM      = 4;
  localparam int WIDTH_DATA_OUT   = 8;
  localparam int TREE_LATENCY_DEF = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } tag_t;

  // A group count of 0 behaves as a single group.
  function automatic logic [7:0] eff_groups(input logic [7:0] ch);
    return (ch == 8'd0) ? 8'd1 : ch;
  endfunction

endpackage

// File: rtl/acc_tag_delay.sv
// Fixed-depth shift line carrying {valid, first, last} alongside the adder tree.
module acc_tag_delay
  import channel_in_acc_ctrl_pkg::*;
#(
  parameter int DEPTH = TREE_LATENCY_DEF
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_in,
  output tag_t tag_out,
  output logic pending
);

  tag_t [DEPTH-1:0] line_q;
  tag_t [DEPTH-1:0] line_d;

  always_comb begin
    line_d[0] = tag_in;
    for (int i = 1; i < DEPTH; i++) begin
      line_d[i] = line_q[i-1];
    end
  end

  // NOTE: this line is state, not a data buffer: stale valid bits after reset
  // would fire phantom accumulations, so every stage is cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  // Any valid beat still travelling behind the output stage.
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      pending = pending | line_q[i].valid;
    end
  end

  assign tag_out = line_q[DEPTH-1];

endmodule

// File: rtl/channel_in_acc_ctrl.sv
// Admits a tile of beats into the 8-channel adder tree, tracks them through its
// pipeline and accumulates the tree outputs per pixel across channel groups.
module channel_in_acc_ctrl
  import channel_in_acc_ctrl_pkg::*;
#(
  parameter int TREE_LATENCY = TREE_LATENCY_DEF,
  parameter int LANE_W       = WIDTH_DATA_OUT * 2,
  parameter int LANES        = PICTURE_NUM
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [7:0]              ch_group_num,
  input  logic [15:0]             pixel_num,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*LANE_W-1:0] tree_data,
  output logic [LANES*LANE_W-1:0] out_data,
  output logic                    out_valid,
  output logic                    busy,
  output logic                    done
);

  localparam int DW = LANES * LANE_W;

  state_e          state_q, state_d;
  logic [7:0]      grp_num_q, grp_num_d;
  logic [7:0]      grp_cnt_q, grp_cnt_d;
  logic [15:0]     pix_num_q, pix_num_d;
  logic [15:0]     pix_cnt_q, pix_cnt_d;
  logic [DW-1:0]   acc_q, acc_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            accept;
  logic            grp_last;
  logic            pix_last;
  logic [DW-1:0]   lane_sum;
  logic [DW-1:0]   acc_next;
  tag_t            tag_in;
  tag_t            tag_out;
  logic            pending;

  assign accept   = in_valid && in_ready_q;
  assign grp_last = (grp_cnt_q == grp_num_q - 8'd1);
  assign pix_last = (pix_cnt_q == pix_num_q - 16'd1);

  always_comb begin
    tag_in.valid = accept;
    tag_in.first = (grp_cnt_q == 8'd0);
    tag_in.last  = grp_last;
  end

  acc_tag_delay #(
    .DEPTH(TREE_LATENCY)
  ) u_tag_delay (
    .clk    (clk),
    .rst    (rst),
    .tag_in (tag_in),
    .tag_out(tag_out),
    .pending(pending)
  );

  // Independent per-lane adders; each wraps modulo 2^LANE_W with no carry out.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign lane_sum[i*LANE_W +: LANE_W] = acc_q[i*LANE_W +: LANE_W]
                                        + tree_data[i*LANE_W +: LANE_W];
  end

  assign acc_next = tag_out.first ? tree_data : lane_sum;

  // NOTE: every _d gets its hold value first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    grp_num_d   = grp_num_q;
    grp_cnt_d   = grp_cnt_q;
    pix_num_d   = pix_num_q;
    pix_cnt_d   = pix_cnt_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          grp_num_d = eff_groups(ch_group_num);
          pix_num_d = pixel_num;
          grp_cnt_d = 8'd0;
          pix_cnt_d = 16'd0;
          state_d   = (pixel_num == 16'd0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept) begin
          if (grp_last) begin
            grp_cnt_d = 8'd0;
            pix_cnt_d = pix_cnt_q + 16'd1;
            if (pix_last) state_d = ST_DRAIN;
          end else begin
            grp_cnt_d = grp_cnt_q + 8'd1;
          end
        end
      end
      ST_DRAIN: begin
        // Final result leaves this edge and nothing follows it in the line.
        if (!pending && tag_out.valid && tag_out.last) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (tag_out.valid) begin
      acc_d = acc_next;
      if (tag_out.last) begin
        out_data_d  = acc_next;
        out_valid_d = 1'b1;
      end
    end

    in_ready_d = (state_d == ST_RUN);
    // busy covers the done pulse, which trails the DONE state by one cycle.
    busy_d     = (state_d != ST_IDLE) || (state_q == ST_DONE);
    done_d     = (state_q == ST_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grp_num_q   <= 8'd1;
      grp_cnt_q   <= 8'd0;
      pix_num_q   <= 16'd0;
      pix_cnt_q   <= 16'd0;
      acc_q       <= '0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      grp_num_q   <= grp_num_d;
      grp_cnt_q   <= grp_cnt_d;
      pix_num_q   <= pix_num_d;
      pix_cnt_q   <= pix_cnt_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_channel_in_acc_ctrl.sv
// Scoreboard bench for channel_in_acc_ctrl with a behavioural adder-tree delay.
`timescale 1ns/1ps
module tb_channel_in_acc_ctrl;

  localparam int TL = 7;
  localparam int LW = 16;
  localparam int NL = 4;
  localparam int DW = LW * NL;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [7:0]    ch_group_num;
  logic [15:0]   pixel_num;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] tree_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          busy;
  logic          done;

  logic [DW-1:0] beat_bus;
  logic [DW-1:0] pipe [TL];
  logic [DW-1:0] sb [$];

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  int n_ov;
  int first_ov;
  int last_ov;

  channel_in_acc_ctrl #(
    .TREE_LATENCY(TL),
    .LANE_W      (LW),
    .LANES       (NL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .ch_group_num(ch_group_num),
    .pixel_num   (pixel_num),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .tree_data   (tree_data),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural tree: an accepted beat reappears TL cycles later.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TL; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= (in_valid && in_ready) ? beat_bus : '0;
      for (int i = 1; i < TL; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign tree_data = pipe[TL-1];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      n_ov++;
      if (first_ov < 0) first_ov = cyc;
      last_ov = cyc;
      check("ov_has_expected", sb.size() > 0, 1);
      if (sb.size() > 0) check("out_data", out_data, sb.pop_front());
    end
  end

  function automatic logic [DW-1:0] beat(input int mode, input int p, input int g);
    logic [DW-1:0] b;
    logic [LW-1:0] v;
    b = '0;
    for (int i = 0; i < NL; i++) begin
      case (mode)
        0: v = LW'(p);
        1: v = LW'(10 * (g + 1));
        2: begin
          case (i)
            0:       v = (g == 0) ? 16'h7FFF : 16'h0002;
            1:       v = (g == 0) ? 16'h0001 : 16'h0000;
            default: v = (g == 0) ? 16'hFFFF : 16'h0001;
          endcase
        end
        default: v = LW'((p * 4099 + g * 517 + i * 7919 + 14940) * 40503);
      endcase
      b[i*LW +: LW] = v;
    end
    return b;
  endfunction

  task automatic run_tile(input string name, input int g_cfg, input int p_cfg,
                          input int mode, input bit gaps, input bit spurious);
    int            g_eff, total, k, budget, start_cyc, done_cyc;
    bit            tog, got_done, busy_at_done;
    logic [DW-1:0] exp, b;
    logic [LW-1:0] s;

    g_eff = (g_cfg == 0) ? 1 : g_cfg;
    total = g_eff * p_cfg;
    for (int p = 0; p < p_cfg; p++) begin
      exp = '0;
      for (int l = 0; l < NL; l++) begin
        s = '0;
        for (int g = 0; g < g_eff; g++) begin
          b = beat(mode, p, g);
          s = s + b[l*LW +: LW];
        end
        exp[l*LW +: LW] = s;
      end
      sb.push_back(exp);
    end
    n_ov = 0; first_ov = -1; last_ov = -1;

    if (spurious) begin
      repeat (3) begin
        @(negedge clk);
        in_valid = 1'b1;
        beat_bus = '1;
      end
    end

    @(negedge clk);
    start        = 1'b1;
    ch_group_num = g_cfg[7:0];
    pixel_num    = p_cfg[15:0];
    start_cyc    = cyc;
    @(negedge clk);
    start        = 1'b0;
    ch_group_num = 8'hAA;
    pixel_num    = 16'hBEEF;

    k = 0; tog = 1'b0; budget = 0;
    while (k < total && budget < 2000) begin
      tog      = ~tog;
      in_valid = gaps ? tog : 1'b1;
      start    = gaps && (budget == 4);
      beat_bus = beat(mode, k / g_eff, k % g_eff);
      if (in_valid && in_ready) k++;
      budget++;
      @(negedge clk);
    end
    check({name, ":beats_accepted"}, k, total);
    start    = 1'b0;
    in_valid = spurious;
    beat_bus = '1;

    got_done = 1'b0; done_cyc = 0; busy_at_done = 1'b0;
    for (int i = 0; i < 1000 && !got_done; i++) begin
      if (done) begin
        got_done     = 1'b1;
        done_cyc     = cyc;
        busy_at_done = busy;
      end else begin
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    check({name, ":done_seen"}, got_done, 1);
    check({name, ":busy_at_done"}, busy_at_done, 1);
    check({name, ":ov_count"}, n_ov, p_cfg);
    check({name, ":sb_left"}, sb.size(), 0);
    if (p_cfg == 0) check({name, ":done_latency"}, done_cyc - start_cyc, 2);
    else            check({name, ":done_after_ov"}, done_cyc - last_ov, 1);
    if (mode == 0 && !gaps && p_cfg > 0) begin
      check({name, ":first_ov_latency"}, first_ov - start_cyc, TL + 2);
      check({name, ":burst_span"}, last_ov - first_ov, p_cfg - 1);
    end
    @(negedge clk);
    check({name, ":busy_dropped"}, busy, 0);
    check({name, ":done_one_cycle"}, done, 0);
    sb.delete();
  endtask

  task automatic reset_abort_test();
    bit saw_done, saw_ov, entered_drain;
    sb.delete();
    @(negedge clk);
    start = 1'b1; ch_group_num = 8'd3; pixel_num = 16'd2;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; beat_bus = beat(3, 0, 0);
    entered_drain = 1'b0;
    for (int i = 0; i < 50 && !entered_drain; i++) begin
      @(negedge clk);
      if (i > 1 && !in_ready) entered_drain = 1'b1;
    end
    check("rst:reached_drain", entered_drain && busy, 1);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check("rst:in_ready", in_ready, 0);
    check("rst:out_valid", out_valid, 0);
    check("rst:busy", busy, 0);
    check("rst:done", done, 0);
    check("rst:out_data", out_data, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0; saw_ov = 1'b0;
    repeat (20) begin
      @(negedge clk);
      saw_done = saw_done | done;
      saw_ov   = saw_ov | out_valid;
    end
    check("rst:no_done", saw_done, 0);
    check("rst:no_out_valid", saw_ov, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ch_group_num = '0; pixel_num = '0;
    in_valid = 1'b0; beat_bus = '0;
    n_ov = 0; first_ov = -1; last_ov = -1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset:in_ready", in_ready, 0);
    check("reset:out_valid", out_valid, 0);
    check("reset:busy", busy, 0);
    check("reset:done", done, 0);
    check("reset:out_data", out_data, 0);

    run_tile("g1p4",      1, 4, 0, 1'b0, 1'b0);
    run_tile("g3p2",      3, 2, 1, 1'b0, 1'b0);
    run_tile("wrap",      2, 1, 2, 1'b0, 1'b0);
    run_tile("rand",      3, 5, 3, 1'b0, 1'b0);
    run_tile("rand_gaps", 3, 5, 3, 1'b1, 1'b1);
    run_tile("zero_pix",  4, 0, 0, 1'b0, 1'b0);
    run_tile("g0",        0, 3, 0, 1'b0, 1'b0);
    run_tile("rand_pre",  2, 2, 3, 1'b0, 1'b0);
    reset_abort_test();
    run_tile("after_rst", 3, 2, 1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/channel_in_acc_ctrl.md
# channel_in_acc_ctrl

Sequencer and accumulator for the 8-input-channel adder tree (`channel_in_eight_times_acc`). It admits a tile of beats into the tree, tracks each beat through the tree's fixed pipeline, and accumulates the tree outputs over the configured number of 8-channel groups. One result per output pixel is emitted with a valid strobe, and completion of the tile is signalled. It sits between the convolution input buffer/MAC array and the output quantisation stage.

## Interface
- `TREE_LATENCY`, default 7: cycles from a beat entering the tree to its sum appearing at the tree output (3 adder stages + 4 output registers).
- `LANE_W`, default `` `WIDTH_DATA_OUT*2 ``: width of one lane.
- `LANES`, default `` `PICTURE_NUM ``: number of lanes.
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle tile start pulse; sampled only in IDLE.
- `ch_group_num` in 8: number of 8-channel groups per pixel; latched on `start`; 0 is treated as 1.
- `pixel_num` in 16: output pixels per tile; latched on `start`.
- `in_valid` in 1: upstream is presenting a beat to the tree this cycle.
- `in_ready` out 1: the beat is accepted. Equals 1 only in RUN.
- `tree_data` in LANES*LANE_W: adder-tree output.
- `out_data` out LANES*LANE_W: accumulated pixel result.
- `out_valid` out 1: one-cycle strobe qualifying `out_data`.
- `busy` out 1: high when not in IDLE.
- `done` out 1: one-cycle pulse at tile end.

## Operation
- **FSM states**
  - IDLE → RUN on `start`. If the latched `pixel_num` is 0, IDLE → DONE instead.
  - RUN → DRAIN on acceptance of the last beat (last group of the last pixel).
  - DRAIN → DONE when the delay line holds no valid beat and the final `out_valid` has been issued.
  - DONE → IDLE unconditionally after one cycle.
- **Beat acceptance:** a beat is accepted when `in_valid && in_ready`. Beats arriving without `in_ready` are ignored and not counted.
- **Ordering:** beats arrive group-inner, i.e. for each pixel, groups 0..G-1 on consecutive accepted beats. Gaps between beats are allowed.
- **Counters:** `grp_cnt` counts 0..G-1 and wraps to 0. `pix_cnt` increments on each `grp_cnt` wrap.
- **Tags:** every accepted beat pushes tag {valid, first = (`grp_cnt`==0), last = (`grp_cnt`==G-1)} into a TREE_LATENCY-deep shift line. When G==1, first and last are both set.
- **At the line output, when the tag is valid:**
  - first: `acc` <= `tree_data`; otherwise `acc` <= `acc` + `tree_data`.
  - last: `out_data` <= (first ? `tree_data` : `acc` + `tree_data`) and `out_valid` <= 1.
- **Arithmetic:** lane-wise two's-complement add, LANE_W bits per lane. The sum wraps modulo 2^LANE_W. There is no saturation and no carry between lanes.
- `start` while busy is ignored. Latched configuration never changes mid-tile.

## Timing
- **Reset values:** all outputs 0 (`in_ready`, `out_valid`, `busy`, `done`, `out_data`), state IDLE, counters 0, tag line cleared, `acc` 0.
- **Reset mid-tile:** immediate abort. In-flight tags are discarded and no `done` is issued.
- **RUN entry:** `in_ready` rises the cycle after `start`.
- **Acceptance:** `in_ready` falls the cycle after the last beat is accepted.
- **Latency:** a last-group beat accepted at cycle t gives `out_valid` at t+TREE_LATENCY+1.
- **Done:** `done` is asserted the cycle after the final `out_valid`, with `busy` still high. `busy` drops the following cycle.
- **Zero-pixel tile:** with `pixel_num`==0, `done` pulses 2 cycles after `start`, with no `out_valid`.
- **Simultaneous events:** a tag entering and a tag leaving the line in the same cycle are both handled. `out_valid` may be asserted on consecutive cycles when G==1.

## Structure
- The shared defines header provides `PICTURE_NUM`, `WIDTH_DATA_OUT`, the FSM state encodings (IDLE/RUN/DRAIN/DONE) and `TREE_LATENCY_DEF`.
- Sub-module `acc_tag_delay`: a parameterised-depth shift line of {valid, first, last}, with asynchronous clear on `rst`.
- Lane-wise add is a generate loop inside the top module. It does not reuse the tree adders.

## Test plan
- G=1, P=4, `in_valid` held high, each lane = pixel index → 4 back-to-back `out_valid` strobes, first at `start`+1+TREE_LATENCY+1, data 0,1,2,3; `done` 1 cycle after the last strobe.
- G=3, P=2, lane data 10, 20, 30 per group → `out_valid` ×2 with every lane = 60; `acc` reloads on the second pixel (no carry-over).
- Wrap: LANE_W=16, G=2, lanes 0x7FFF + 0x0002 → 0x8001; neighbouring lane unaffected.
- `in_valid` toggling 1/0 plus spurious `in_valid` in IDLE/DRAIN → only RUN-accepted beats are counted; results are identical to the gap-free run.
- `pixel_num`=0 → no `out_valid`; `done` at `start`+2. `ch_group_num`=0 → behaves as G=1.
- `rst` asserted during DRAIN → all outputs 0 next edge; no `done`; a fresh `start` runs a clean tile.
